// File: rtl/branch_predictor_pkg.sv
// Shared types for the IF-stage branch target buffer: direction-counter states,
// table entry layout and the counter step function.
package branch_predictor_pkg;

    localparam int unsigned BP_TAG_MAX = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_t;

    // Tag field is sized for the smallest table; narrower tags are zero-extended.
    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        logic [31:0]           target;
        bp_state_t             state;
    } bp_entry_t;

    function automatic bp_state_t bp_next_state(input bp_state_t s, input logic taken);
        bp_state_t n;
        n = s;
        case (s)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_if.sv
// Bundle of the predictor's fetch-side and resolve-side signals.
interface bp_if;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    modport bp (
        input  pc_if, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, correct_pc, perf_branches, perf_mispredicts
    );

    modport tb (
        output pc_if, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, correct_pc, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/bp_perf_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bp_perf_counter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (en && inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; predicts in IF, trains and
// flags redirects from resolved branches in EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned TAG_W   = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    bp_entry_t tbl [ENTRIES];

    function automatic logic [BP_TAG_MAX-1:0] tag_of(input logic [31:0] pc);
        logic [TAG_W-1:0] t;
        t = pc[31:IDX_W+2];
        return BP_TAG_MAX'(t);
    endfunction

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    bp_entry_t        rd_ent;
    bp_entry_t        wr_ent;
    logic             rd_hit;
    logic             wr_hit;

    always_comb begin
        rd_idx      = pc_if[IDX_W+1:2];
        rd_ent      = tbl[rd_idx];
        rd_hit      = rd_ent.valid && (rd_ent.tag == tag_of(pc_if));
        pred_taken  = rd_hit && rd_ent.state[1];
        pred_target = pred_taken ? rd_ent.target : pc_if + 32'd4;
    end

    always_comb begin
        wr_idx = upd_pc[IDX_W+1:2];
        wr_ent = tbl[wr_idx];
        wr_hit = wr_ent.valid && (wr_ent.tag == tag_of(upd_pc));
    end

    always_comb begin
        mispredict = 1'b0;
        correct_pc = '0;
        if (upd_en) begin
            mispredict = (upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target));
            correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
        end
    end

    // Lookup reads pre-edge contents; a same-index write lands only at the edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, state: WNT};
            end
        end else if (upd_en) begin
            if (wr_hit) begin
                tbl[wr_idx].state <= bp_next_state(wr_ent.state, upd_taken);
                if (upd_taken) begin
                    tbl[wr_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                tbl[wr_idx] <= '{valid: 1'b1, tag: tag_of(upd_pc), target: upd_target, state: WT};
            end
        end
    end

    bp_perf_counter u_perf_branches (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (upd_en),
        .inc   (1'b1),
        .count (perf_branches)
    );

    bp_perf_counter u_perf_mispredicts (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (upd_en),
        .inc   (mispredict),
        .count (perf_mispredicts)
    );

endmodule
